clock_divider: RTL and testbench

//   Synthesizable, multi-channel, programmable clock divider with per-channel run control.

---
 rtl/clock_divider_if.sv | 29 ++
 rtl/clock_divider.sv | 119 +++++++++++
 tb/tb_clock_divider.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_if.sv
// Control and status bundle for the multi-channel clock divider.
//   enable    : per-channel run request, sampled on the system clock
//   divisor   : packed half-period divisors, channel k at [k*WIDTH +: WIDTH]
//   div_clock : divided clock per channel, registered
//   rise      : one-cycle pulse when div_clock goes high
//   fall      : one-cycle pulse when div_clock goes low
//   running   : high while the channel is in its HIGH or LOW phase
// master drives enable/divisor and observes the outputs; slave is the divider.
interface clock_divider_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);
  logic [CHANNELS-1:0]       enable;
  logic [CHANNELS*WIDTH-1:0] divisor;
  logic [CHANNELS-1:0]       div_clock;
  logic [CHANNELS-1:0]       rise;
  logic [CHANNELS-1:0]       fall;
  logic [CHANNELS-1:0]       running;

  modport master (
    output enable, divisor,
    input  div_clock, rise, fall, running
  );

  modport slave (
    input  enable, divisor,
    output div_clock, rise, fall, running
  );
endinterface

// File: rtl/clock_divider.sv
// Multi-channel programmable clock divider with glitch-free run control.
// Each channel produces a 50%-duty clock of period 2*D system cycles, where
// D is the channel divisor (0 treated as 1). The divisor is captured at each
// rising edge of the divided clock so a period is never cut short, and the
// run request is only honoured from IDLE or on the last LOW cycle.
//   clock : system clock, all logic on the rising edge
//   reset : synchronous, active-high; forces every channel to IDLE, outputs 0
//   bus   : clock_divider_if slave (enable, divisor in; div_clock, rise,
//           fall, running out)
module clock_divider #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
) (
  input  logic          clock,
  input  logic          reset,
  clock_divider_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic [CHANNELS-1:0] clk_vec;
  logic [CHANNELS-1:0] rise_vec;
  logic [CHANNELS-1:0] fall_vec;
  logic [CHANNELS-1:0] running_vec;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
      state_t           state_reg;
      logic [WIDTH-1:0] cnt_reg;
      logic [WIDTH-1:0] div_reg;
      logic             clk_reg;
      logic             rise_reg;
      logic             fall_reg;
      logic             running_reg;
      logic [WIDTH-1:0] div_in;
      logic [WIDTH-1:0] div_eff;

      assign div_in  = bus.divisor[gi*WIDTH +: WIDTH];
      // A zero divisor would otherwise underflow the counter; run it as 1.
      assign div_eff = (div_in == '0) ? WIDTH'(1) : div_in;

      always_ff @(posedge clock) begin
        if (reset) begin
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          div_reg     <= '0;
          clk_reg     <= 1'b0;
          rise_reg    <= 1'b0;
          fall_reg    <= 1'b0;
          running_reg <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          case (state_reg)
            IDLE: begin
              clk_reg     <= 1'b0;
              running_reg <= 1'b0;
              if (bus.enable[gi]) begin
                state_reg   <= HIGH;
                div_reg     <= div_eff;
                cnt_reg     <= div_eff - WIDTH'(1);
                clk_reg     <= 1'b1;
                rise_reg    <= 1'b1;
                running_reg <= 1'b1;
              end
            end
            HIGH: begin
              if (cnt_reg == '0) begin
                // Low phase reuses the divisor captured at the rise.
                state_reg <= LOW;
                cnt_reg   <= div_reg - WIDTH'(1);
                clk_reg   <= 1'b0;
                fall_reg  <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg - WIDTH'(1);
              end
            end
            LOW: begin
              if (cnt_reg == '0) begin
                if (bus.enable[gi]) begin
                  state_reg <= HIGH;
                  div_reg   <= div_eff;
                  cnt_reg   <= div_eff - WIDTH'(1);
                  clk_reg   <= 1'b1;
                  rise_reg  <= 1'b1;
                end else begin
                  state_reg   <= IDLE;
                  running_reg <= 1'b0;
                end
              end else begin
                cnt_reg <= cnt_reg - WIDTH'(1);
              end
            end
            default: begin
              state_reg   <= IDLE;
              clk_reg     <= 1'b0;
              running_reg <= 1'b0;
            end
          endcase
        end
      end

      assign clk_vec[gi]     = clk_reg;
      assign rise_vec[gi]    = rise_reg;
      assign fall_vec[gi]    = fall_reg;
      assign running_vec[gi] = running_reg;
    end
  endgenerate

  assign bus.div_clock = clk_vec;
  assign bus.rise      = rise_vec;
  assign bus.fall      = fall_vec;
  assign bus.running   = running_vec;

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider. Each check compares one channel's
// {div_clock, rise, fall, running} against a hand-computed nibble, sampled
// 1 ns after the rising edge.
module tb_clock_divider;

  localparam int CHANNELS = 2;
  localparam int WIDTH    = 8;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  clock_divider_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) bus ();

  clock_divider #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_div(input int ch, input int value);
    bus.divisor[ch*WIDTH +: WIDTH] = WIDTH'(value);
  endtask

  // Expected nibble order: {div_clock, rise, fall, running}
  task automatic check(input string tag, input int ch, input logic [3:0] expected);
    logic [3:0] observed;
    observed = {bus.div_clock[ch], bus.rise[ch], bus.fall[ch], bus.running[ch]};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s ch%0d observed=%b expected=%b (clk,rise,fall,run)", tag, ch, observed, expected);
    end
    $display("check %-14s ch%0d observed=%b expected=%b", tag, ch, observed, expected);
  endtask

  initial begin
    logic [3:0] p2 [4];
    logic [3:0] t6 [6];
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.enable  = '0;
    bus.divisor = '0;
    tick();
    tick();
    check("reset", 0, 4'b0000);
    check("reset", 1, 4'b0000);
    reset = 1'b0;

    // 1: D=2 held enable -> 1,1,0,0 repeating
    p2[0] = 4'b1101; p2[1] = 4'b1001; p2[2] = 4'b0011; p2[3] = 4'b0001;
    set_div(0, 2);
    bus.enable[0] = 1'b1;
    for (int per = 0; per < 3; per++) begin
      for (int i = 0; i < 4; i++) begin
        tick();
        check("d2_seq", 0, p2[i]);
      end
    end
    check("ch1_idle", 1, 4'b0000);
    bus.enable[0] = 1'b0;
    tick();
    check("d2_stop", 0, 4'b0000);

    // 2: D=0 then D=1 both toggle every cycle
    set_div(0, 0);
    bus.enable[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("d0_toggle", 0, (i % 2 == 0) ? 4'b1101 : 4'b0011);
    end
    set_div(0, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("d1_toggle", 0, (i % 2 == 0) ? 4'b1101 : 4'b0011);
    end
    bus.enable[0] = 1'b0;
    tick();
    check("d1_stop", 0, 4'b0000);

    // 3: D=4, one-cycle enable pulse -> exactly one period
    set_div(0, 4);
    bus.enable[0] = 1'b1;
    tick();
    check("pulse_rise", 0, 4'b1101);
    bus.enable[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pulse_high", 0, 4'b1001);
    end
    tick();
    check("pulse_fall", 0, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pulse_low", 0, 4'b0001);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pulse_idle", 0, 4'b0000);
    end

    // 4: D=3, change to 5 during the 2nd high cycle
    set_div(0, 3);
    bus.enable[0] = 1'b1;
    tick();
    check("chg_rise3", 0, 4'b1101);
    tick();
    check("chg_high3", 0, 4'b1001);
    set_div(0, 5);
    tick();
    check("chg_high3", 0, 4'b1001);
    tick();
    check("chg_fall3", 0, 4'b0011);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("chg_low3", 0, 4'b0001);
    end
    tick();
    check("chg_rise5", 0, 4'b1101);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("chg_high5", 0, 4'b1001);
    end
    tick();
    check("chg_fall5", 0, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("chg_low5", 0, 4'b0001);
    end
    bus.enable[0] = 1'b0;
    tick();
    check("chg_stop", 0, 4'b0000);

    // 5: D=8, reset on 3rd high cycle
    set_div(0, 8);
    bus.enable[0] = 1'b1;
    tick();
    check("rst_rise", 0, 4'b1101);
    tick();
    check("rst_high", 0, 4'b1001);
    tick();
    check("rst_high", 0, 4'b1001);
    reset = 1'b1;
    tick();
    check("rst_mid", 0, 4'b0000);
    reset = 1'b0;
    tick();
    check("rst_restart", 0, 4'b1101);
    reset = 1'b1;
    tick();
    check("rst_priority", 0, 4'b0000);
    reset = 1'b0;
    bus.enable[0] = 1'b0;
    tick();
    check("rst_idle", 0, 4'b0000);

    // 6: ch0 D=1, ch1 D=3, ch1 disabled mid-high
    set_div(0, 1);
    set_div(1, 3);
    bus.enable = 2'b11;
    tick();
    check("ind_rise", 0, 4'b1101);
    check("ind_rise", 1, 4'b1101);
    tick();
    check("ind_ch0", 0, 4'b0011);
    check("ind_ch1", 1, 4'b1001);
    bus.enable[1] = 1'b0;
    t6[0] = 4'b1001; t6[1] = 4'b0011; t6[2] = 4'b0001;
    t6[3] = 4'b0001; t6[4] = 4'b0000; t6[5] = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ind_ch0", 0, (i % 2 == 0) ? 4'b1101 : 4'b0011);
      check("ind_ch1", 1, t6[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
